// File: rtl/keypad_scan_if.sv
// Key-event stream between the keypad scanner and its consumer.
// The scanner drives each 4-bit press code with a valid flag.
// The consumer answers with ready.
interface keypad_scan_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;

    modport master (
        output key_valid,
        output key_code,
        input  key_ready
    );

    modport slave (
        input  key_valid,
        input  key_code,
        output key_ready
    );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner.
// - Drives one active-low row at a time for 2^nr_clk cycles.
// - Assembles a 16-bit frame of the pressed keys.
// - Debounces whole frames.
// - Queues new presses as hex codes on a valid/ready stream.
module keypad_scan #(
    parameter int nr_clk    = 10,
    parameter int db_frames = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic [3:0]      ROW,
    input  logic [3:0]      COL,
    output logic [15:0]     key_state,
    keypad_scan_if.master   key_if
);

    localparam logic [3:0] DB_FRAMES = 4'(db_frames);

    // ------------------------------------------------------------------
    // Column synchronizers.
    // COL is asynchronous and active-low.
    // Each column gets its own 2-flop chain.
    // ------------------------------------------------------------------
    logic [3:0] pressed;

    for (genvar gi = 0; gi < 4; gi++) begin : g_col_sync
        logic meta_reg;
        logic sync_reg;

        // Two-stage synchronizer for one column line.
        always_ff @(posedge clk) begin
            if (rst) begin
                meta_reg <= 1'b0;
                sync_reg <= 1'b0;
            end else begin
                meta_reg <= COL[gi];
                sync_reg <= meta_reg;
            end
        end

        assign pressed[gi] = ~sync_reg;
    end

    // ------------------------------------------------------------------
    // Row scan time base.
    // ------------------------------------------------------------------
    logic [nr_clk-1:0] counter_reg;
    logic [1:0]        row_idx_reg;
    logic              scan_tick;
    logic              frame_end;

    assign scan_tick = &counter_reg;
    assign frame_end = scan_tick && (row_idx_reg == 2'd3);
    assign ROW       = ~(4'b0001 << row_idx_reg);

    // Dwell counter wraps freely.
    // The row advances on the last cycle of each dwell.
    always_ff @(posedge clk) begin
        if (rst) begin
            counter_reg <= '0;
            row_idx_reg <= 2'd0;
        end else begin
            counter_reg <= counter_reg + 1'b1;
            if (scan_tick) begin
                row_idx_reg <= row_idx_reg + 2'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame capture.
    // ------------------------------------------------------------------
    logic [15:0] frame_new_reg;
    logic [15:0] frame_full;

    // The row-3 nibble is taken straight from the synchronizer.
    // The frame-end decision then sees the complete frame on the same edge.
    assign frame_full = {pressed, frame_new_reg[11:0]};

    // Latch the sensed columns of the driven row at the end of its dwell.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_new_reg <= '0;
        end else if (scan_tick) begin
            frame_new_reg[{row_idx_reg, 2'b00} +: 4] <= pressed;
        end
    end

    // ------------------------------------------------------------------
    // Frame debounce.
    // ------------------------------------------------------------------
    logic [15:0] frame_prev_reg;
    logic [3:0]  stable_cnt_reg;
    logic [15:0] key_state_reg;
    logic        frame_match;
    logic [4:0]  stable_inc;
    logic        debounce_ok;
    logic [15:0] new_press;

    assign frame_match = (frame_full == frame_prev_reg);
    assign stable_inc  = {1'b0, stable_cnt_reg} + 5'd1;
    assign debounce_ok = frame_match && (stable_inc >= {1'b0, DB_FRAMES});
    assign new_press   = (frame_end && debounce_ok) ? (frame_full & ~key_state_reg) : 16'h0000;

    // Count consecutive identical frames.
    // Commit the frame once it has held long enough.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_prev_reg <= '0;
            stable_cnt_reg <= '0;
            key_state_reg  <= '0;
        end else if (frame_end) begin
            frame_prev_reg <= frame_full;
            if (frame_match) begin
                stable_cnt_reg <= (stable_cnt_reg == DB_FRAMES) ? DB_FRAMES : stable_cnt_reg + 4'd1;
            end else begin
                stable_cnt_reg <= 4'd0;
            end
            if (debounce_ok) begin
                key_state_reg <= frame_full;
            end
        end
    end

    assign key_state = key_state_reg;

    // ------------------------------------------------------------------
    // Pending queue and output stage.
    // ------------------------------------------------------------------
    logic [15:0] pending_reg;
    logic [15:0] pending_next;
    logic        key_valid_reg;
    logic [3:0]  key_code_reg;
    logic        out_load;
    logic        pend_any;
    logic [3:0]  pend_idx;
    logic [15:0] pend_clear;

    assign out_load = ~key_valid_reg | key_if.key_ready;
    assign pend_any = |pending_reg;

    // Pick the lowest-index pending key.
    // The set and clear terms are combined, so a press arriving on a
    // load cycle is never lost.
    always_comb begin
        pend_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (pending_reg[i]) begin
                pend_idx = 4'(i);
            end
        end
        pend_clear   = (out_load && pend_any) ? (16'h0001 << pend_idx) : 16'h0000;
        pending_next = (pending_reg & ~pend_clear) | new_press;
    end

    // Pending-event register.
    // Also the output register, which holds while stalled by the consumer.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_reg   <= '0;
            key_valid_reg <= 1'b0;
            key_code_reg  <= 4'd0;
        end else begin
            pending_reg <= pending_next;
            if (out_load) begin
                key_valid_reg <= pend_any;
                if (pend_any) begin
                    key_code_reg <= pend_idx;
                end
            end
        end
    end

    assign key_if.key_valid = key_valid_reg;
    assign key_if.key_code  = key_code_reg;

endmodule

// File: tb/tb_keypad_scan.sv
// Testbench for keypad_scan.
// - A keypad model maps the driven row onto the column lines.
// - A frame-level debounce model predicts key_state and the press events.
// - A monitor scores every handshake against the expected-event queue.
module tb_keypad_scan;

    localparam int NR_CLK = 2;
    localparam int DB     = 2;
    localparam int DWELL  = 4;
    localparam int FRAME  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  ROW;
    logic [3:0]  COL;
    logic [15:0] key_state;

    keypad_scan_if kif ();

    keypad_scan #(.nr_clk(NR_CLK), .db_frames(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .ROW       (ROW),
        .COL       (COL),
        .key_state (key_state),
        .key_if    (kif)
    );

    always #5 clk = ~clk;

    // Physical keypad: the pressed map pulls the columns of the driven row low.
    logic [15:0] keys = 16'h0000;
    always_comb begin
        COL = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (ROW[r] == 1'b0) begin
                COL = ~keys[r*4 +: 4];
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ph      = 0;
    int hs_count = 0;
    int last_hs_cyc = 0;
    int prev_hs_cyc = 0;
    logic ready_rand  = 1'b0;
    logic ready_force = 1'b0;

    logic [3:0]  exp_q [$];
    logic [15:0] hist [$];
    logic [15:0] state_m = 16'h0000;

    always_ff @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: key_state follows a frame once the last DB+1 frames
    // (the reset state counting as an all-released frame) are identical.
    // Each such commit reports the keys not already in key_state.
    function automatic void model_frame(input logic [15:0] f);
        logic        all_same;
        logic [15:0] fresh;
        hist.push_back(f);
        if (hist.size() > DB + 1) void'(hist.pop_front());
        if (hist.size() == DB + 1) begin
            all_same = 1'b1;
            foreach (hist[i]) if (hist[i] != f) all_same = 1'b0;
            if (all_same) begin
                fresh = f & ~state_m;
                for (int k = 0; k < 16; k++) if (fresh[k]) exp_q.push_back(4'(k));
                state_m = f;
            end
        end
    endfunction

    function automatic void model_reset();
        hist.delete();
        hist.push_back(16'h0000);
        state_m = 16'h0000;
        exp_q.delete();
    endfunction

    // One clock step; the row drive must follow the scan schedule.
    task automatic step();
        logic [3:0] er;
        @(posedge clk); #1;
        ph++;
        er = ~(4'b0001 << ((ph / DWELL) % 4));
        check("row_scan", ROW, er);
    endtask

    task automatic start_frame(input logic [15:0] pat);
        keys = pat;
        model_frame(pat);
    endtask

    task automatic finish_frame();
        do step(); while (ph % FRAME != 0);
        check("key_state", key_state, state_m);
    endtask

    task automatic run_frame(input logic [15:0] pat);
        start_frame(pat);
        finish_frame();
    endtask

    // Reset for one edge, then check the reset state.
    // The scan phase restarts at zero.
    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        ph = 0;
        check("rst_row", ROW, 4'b1110);
        check("rst_valid", kif.key_valid, 1'b0);
        check("rst_code", kif.key_code, 4'h0);
        check("rst_state", key_state, 16'h0000);
        rst = 1'b0;
    endtask

    // Consumer ready generator.
    // In random mode ready never stays low two cycles running.
    initial begin
        kif.key_ready = 1'b0;
        forever begin
            @(posedge clk); #2;
            if (ready_rand) begin
                if (!kif.key_ready) kif.key_ready = 1'b1;
                else kif.key_ready = ($urandom_range(0, 3) != 0);
            end else begin
                kif.key_ready = ready_force;
            end
        end
    end

    // Monitor: score handshakes and check that stalled outputs hold.
    initial begin
        logic       stall_prev;
        logic [3:0] stall_code;
        logic [3:0] e;
        stall_prev = 1'b0;
        stall_code = 4'h0;
        forever begin
            @(negedge clk);
            if (stall_prev) begin
                n_tests++;
                if (!(kif.key_valid && kif.key_code == stall_code)) begin
                    n_fail++;
                    $display("FAIL stall_hold: got valid=%b code=%h, expected valid=1 code=%h", kif.key_valid, kif.key_code, stall_code);
                end
            end
            if (!rst && kif.key_valid && kif.key_ready) begin
                n_tests++;
                hs_count++;
                prev_hs_cyc = last_hs_cyc;
                last_hs_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL event: got code %h, expected no event", kif.key_code);
                end else begin
                    e = exp_q.pop_front();
                    $display("[TB] event code=%h expected=%h cycle=%0d", kif.key_code, e, cyc);
                    if (kif.key_code != e) begin
                        n_fail++;
                        $display("FAIL event_code: got %h, expected %h", kif.key_code, e);
                    end
                end
            end
            stall_prev = !rst && kif.key_valid && !kif.key_ready;
            stall_code = kif.key_code;
        end
    end

    initial begin
        int          hs0;
        logic [15:0] pat;
        logic [15:0] prev_pat;
        int          nk;
        int          hold;

        // Reset and idle scan.
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        do_reset();
        ready_rand = 1'b1;
        run_frame(16'h0000);
        run_frame(16'h0000);

        // Single press under backpressure.
        ready_rand  = 1'b0;
        ready_force = 1'b0;
        repeat (3) run_frame(16'h0200);
        for (int f = 0; f < 7; f++) begin
            run_frame(16'h0200);
            check("bp_valid", kif.key_valid, 1'b1);
            check("bp_code", kif.key_code, 4'h9);
        end
        hs0 = hs_count;
        start_frame(16'h0200);
        ready_force = 1'b1;
        step();
        ready_force = 1'b0;
        check("pulse_drop", kif.key_valid, 1'b0);
        check("pulse_hs", hs_count - hs0, 1);
        finish_frame();
        repeat (2) begin
            run_frame(16'h0200);
            check("held_no_event", kif.key_valid, 1'b0);
        end

        // Release, then bounce, then hold.
        ready_rand = 1'b1;
        hs0 = hs_count;
        repeat (3) run_frame(16'h0000);
        check("release_no_event", hs_count - hs0, 0);
        for (int f = 0; f < 5; f++) run_frame((f % 2 == 0) ? 16'h0200 : 16'h0000);
        check("bounce_no_event", hs_count - hs0, 0);
        repeat (3) run_frame(16'h0200);
        check("bounce_one_event", hs_count - hs0, 1);

        // Release and re-press.
        hs0 = hs_count;
        repeat (3) run_frame(16'h0000);
        check("release2_no_event", hs_count - hs0, 0);
        repeat (4) run_frame(16'h0200);
        check("repress_event", hs_count - hs0, 1);

        // Two keys in one frame, consumer always ready.
        ready_rand  = 1'b0;
        ready_force = 1'b1;
        hs0 = hs_count;
        repeat (4) run_frame(16'h1008);
        check("two_key_count", hs_count - hs0, 2);
        check("two_key_b2b", last_hs_cyc - prev_hs_cyc, 1);
        check("two_key_idle", kif.key_valid, 1'b0);

        // Randomized key patterns held for random frame counts.
        ready_rand = 1'b1;
        prev_pat = 16'h1008;
        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                pat = prev_pat;
            end else begin
                pat = 16'h0000;
                nk = $urandom_range(0, 3);
                for (int k = 0; k < nk; k++) pat[$urandom_range(0, 15)] = 1'b1;
            end
            hold = $urandom_range(1, 4);
            repeat (hold) run_frame(pat);
            prev_pat = pat;
        end
        repeat (4) run_frame(16'h0000);
        check("random_drained", exp_q.size(), 0);

        // Reset while an event is presented.
        ready_rand  = 1'b0;
        ready_force = 1'b0;
        repeat (3) run_frame(16'h0200);
        start_frame(16'h0200);
        repeat (5) step();
        check("pre_rst_valid", kif.key_valid, 1'b1);
        check("pre_rst_code", kif.key_code, 4'h9);
        do_reset();
        ready_rand = 1'b1;
        hs0 = hs_count;
        repeat (4) run_frame(16'h0200);
        check("rereport", hs_count - hs0, 1);
        check("final_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
